// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor:
//   state_t        - controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH  - default operand width
//   cnt_width()    - width of the bit-step counter for a given operand width
// -----------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=2.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 3) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bin  in   borrow in
//   d    out  difference bit
//   bout out  borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// using a single full_subtractor with its borrow closed through a register.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   request, sampled only in IDLE
//   a, b        in   operands, captured on the accepted start edge
//   busy        out  high while shifting
//   done        out  one-cycle completion pulse
//   diff        out  registered a - b mod 2^WIDTH
//   borrow_out  out  final borrow (a < b unsigned)
//   overflow    out  signed overflow flag (only with SERIAL_SUB_OVERFLOW_EN)
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned    CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-2:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic [CW-1:0]      r_cnt;
    logic               r_borrow;
    logic               r_bout;
    logic               w_d;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_res;

    full_subtractor u_fs (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Result register keeps only WIDTH-1 bits: the final bit is taken
    // straight from the cell on the last step.
    assign w_res  = {w_d, r_res};
    assign w_last = (r_state == SHIFT) && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res    <= w_res[WIDTH-1:1];
            r_borrow <= w_bout;
            // Return to zero instead of wrapping on the final step.
            r_cnt    <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_res;
                r_bout <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
        end else if (w_last) begin
            // w_d is the result MSB on the final step.
            r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end

    assign overflow = r_ovf;
`endif

    assign busy       = (r_state == SHIFT);
    assign done       = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         overflow;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        int           at;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int at);
        exp_t e;
        int   ua, ub, sa, sb, sr;
        ua = int'(ta);
        ub = int'(tb_v);
        sa = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
        sr = sa - sb;
        e.d  = W'((ua - ub + (1 << W)) % (1 << W));
        e.br = (ua < ub);
        e.ov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
        e.at = at;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.at);
                chk("diff", int'(diff), int'(e.d));
                chk("borrow_out", int'(borrow_out), int'(e.br));
                chk("busy_at_done", int'(busy), 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("overflow", int'(overflow), int'(e.ov));
`endif
            end
        end
    end

    // One operation: start is sampled at the edge after this negedge (T);
    // done is expected visible at the negedge following edge T+W.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        q.push_back(model(ta, tb_v, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < W; i++) begin
            chk("busy_high", int'(busy), 1);
            @(negedge clk);
        end
        chk("busy_low", int'(busy), 0);
        @(negedge clk);
    endtask

    initial begin
        int t0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        chk("rst_borrow", int'(borrow_out), 0);
        rst = 1'b0;

        // Directed vectors
        run_op(8'h05, 8'h03);
        run_op(8'h03, 8'h05);
        run_op(8'h80, 8'h01);
        run_op(8'h00, 8'h00);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'hFF);
        run_op(8'h7F, 8'h80);

        // Start during SHIFT is ignored
        @(negedge clk);
        a = 8'h10; b = 8'h01; start = 1'b1;
        q.push_back(model(8'h10, 8'h01, cyc + 1 + W));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hFF; b = 8'h01; start = 1'b1;   // sampled at T+3
        @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        // Reset mid-operation
        @(negedge clk);
        a = 8'h55; b = 8'h22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_borrow", int'(borrow_out), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (W + 4) @(negedge clk);
        run_op(8'h55, 8'h22);

        // Back-to-back with start held high
        @(negedge clk);
        a = 8'h9C; b = 8'h3A; start = 1'b1;
        t0 = cyc + 1;
        q.push_back(model(8'h9C, 8'h3A, t0 + W));
        @(negedge clk);
        a = 8'h21; b = 8'hC4;
        q.push_back(model(8'h21, 8'hC4, t0 + W + 2 + W));
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        a = '0; b = '0;
        repeat (W + 3) @(negedge clk);

        // Randomized vectors
        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom));
        end

        repeat (W + 4) @(negedge clk);
        chk("pending_results", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
